// File: rtl/data_array_arbiter.sv
// data_array_arbiter
//   Shares one single-port data array (1-cycle read latency, active-low select
//   and write enable) between port A (CPU hit path) and port B (fill/writeback).
//   A normally wins; B is forced through after waiting STARVE_LIMIT cycles.
//   Burst locks keep one port as owner. Read data is steered back to the
//   port that issued the read.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   a_* / b_*                  requester ports: req, we, lock, addr, wmask,
//                              wdata in; gnt, rvalid, rdata out
//   csb0, web0, addr0,         SRAM drive (select and write enable active low)
//   wmask0, din0
//   dout0                      SRAM read data, valid one cycle after the read
module data_array_arbiter #(
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned NUM_WMASKS   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StLockA,
        StLockB
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_owner_q, rd_owner_d;  // 0 = A, 1 = B
    logic [DATA_WIDTH-1:0] a_hold_q, b_hold_q;
    logic                  a_win, b_win;

    // Winner selection; nothing wins while reset is asserted.
    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (rst_n) begin
            case (state_q)
                StIdle: begin
                    if (a_req && b_req) begin
                        if (wait_cnt_q >= StarveMax) b_win = 1'b1;
                        else                         a_win = 1'b1;
                    end else begin
                        a_win = a_req;
                        b_win = b_req;
                    end
                end
                StLockA: a_win = a_req;
                StLockB: b_win = b_req;
                default: ;
            endcase
        end
    end

    // Lock transitions are registered, so the other port can only win from
    // the cycle after the owner lets go.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (a_win && a_lock)      state_d = StLockA;
                else if (b_win && b_lock) state_d = StLockB;
            end
            StLockA: if (!a_req || !a_lock) state_d = StIdle;
            StLockB: if (!b_req || !b_lock) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // B starvation counter keeps counting while A holds a lock.
    always_comb begin
        wait_cnt_d = 4'd0;
        if (b_req && !b_win) begin
            wait_cnt_d = (wait_cnt_q >= StarveMax) ? StarveMax : 4'(wait_cnt_q + 4'd1);
        end
    end

    always_comb begin
        rd_pend_d  = (a_win && !a_we) || (b_win && !b_we);
        rd_owner_d = b_win;
    end

    // SRAM drive mux.
    always_comb begin
        csb0   = 1'b1;
        web0   = 1'b1;
        addr0  = '0;
        wmask0 = '0;
        din0   = '0;
        if (a_win) begin
            csb0   = 1'b0;
            web0   = ~a_we;
            addr0  = a_addr;
            wmask0 = a_wmask;
            din0   = a_wdata;
        end else if (b_win) begin
            csb0   = 1'b0;
            web0   = ~b_we;
            addr0  = b_addr;
            wmask0 = b_wmask;
            din0   = b_wdata;
        end
    end

    // Read return: the owner sees dout0 live, the other port keeps its last data.
    always_comb begin
        a_gnt    = a_win;
        b_gnt    = b_win;
        a_rvalid = rd_pend_q && !rd_owner_q;
        b_rvalid = rd_pend_q && rd_owner_q;
        a_rdata  = a_rvalid ? dout0 : a_hold_q;
        b_rdata  = b_rvalid ? dout0 : b_hold_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            if (a_rvalid) a_hold_q <= dout0;
            if (b_rvalid) b_hold_q <= dout0;
        end
    end

endmodule

// File: tb/tb_data_array_arbiter.sv
// tb_data_array_arbiter
//   Directed scenarios followed by randomized requesters, all checked cycle by
//   cycle against a behavioural model of the arbiter plus an SRAM model.
module tb_data_array_arbiter;

    localparam int DW    = 256;
    localparam int AW    = 4;
    localparam int NW    = 32;
    localparam int LIMIT = 4;

    logic          clk, rst_n;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [NW-1:0] a_wmask, b_wmask;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          csb0, web0;
    logic [AW-1:0] addr0;
    logic [NW-1:0] wmask0;
    logic [DW-1:0] din0, dout0;

    data_array_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr),
        .a_wmask(a_wmask), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr),
        .b_wmask(b_wmask), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .b_rdata(b_rdata),
        .csb0(csb0), .web0(web0), .addr0(addr0), .wmask0(wmask0), .din0(din0),
        .dout0(dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] expand(input logic [NW-1:0] m);
        logic [DW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    // SRAM model driven by the DUT's SRAM pins.
    logic [DW-1:0] sram [16] = '{default: '0};
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) sram[addr0] <= (sram[addr0] & ~expand(wmask0)) | (din0 & expand(wmask0));
            else       dout0 <= sram[addr0];
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [16] = '{default: '0};
    int            vectors = 0;
    int            miscompares = 0;
    int            exp_win = 0;   // 0 none, 1 A, 2 B
    int            lock_st = 0;   // 0 none, 1 A, 2 B
    int            waited = 0;
    int            pend = 0;      // 0 none, 1 A, 2 B
    logic [DW-1:0] pend_data, a_last, b_last;
    bit            a_last_ok = 0, b_last_ok = 0;
    int            a_gnt_seen = 0, b_gnt_seen = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic exp_web;
        exp_win = 0;
        if (rst_n) begin
            if (lock_st == 1)      exp_win = a_req ? 1 : 0;
            else if (lock_st == 2) exp_win = b_req ? 2 : 0;
            else if (a_req && b_req) exp_win = (waited >= LIMIT) ? 2 : 1;
            else if (a_req)        exp_win = 1;
            else if (b_req)        exp_win = 2;
        end
        exp_web = (exp_win == 1) ? ~a_we : (exp_win == 2) ? ~b_we : 1'b1;
        vectors++;
        if (a_gnt === 1'b1) a_gnt_seen++;
        if (b_gnt === 1'b1) b_gnt_seen++;
        chk("a_gnt", a_gnt, exp_win == 1);
        chk("b_gnt", b_gnt, exp_win == 2);
        chk("csb0", csb0, exp_win == 0);
        chk("web0", web0, exp_web);
        if (exp_win == 1) begin
            chk("addr0", addr0, a_addr); chk("wmask0", wmask0, a_wmask);
            if (a_we) chk("din0", din0, a_wdata);
        end else if (exp_win == 2) begin
            chk("addr0", addr0, b_addr); chk("wmask0", wmask0, b_wmask);
            if (b_we) chk("din0", din0, b_wdata);
        end else if (!rst_n) begin
            chk("addr0_rst", addr0, 0); chk("wmask0_rst", wmask0, 0); chk("din0_rst", din0, 0);
        end
        chk("a_rvalid", a_rvalid, pend == 1);
        chk("b_rvalid", b_rvalid, pend == 2);
        if (pend == 1) chk("a_rdata", a_rdata, pend_data);
        else if (a_last_ok) chk("a_rdata_hold", a_rdata, a_last);
        if (pend == 2) chk("b_rdata", b_rdata, pend_data);
        else if (b_last_ok) chk("b_rdata_hold", b_rdata, b_last);
    endtask

    task automatic update_model();
        if (!rst_n) begin
            lock_st = 0; waited = 0; pend = 0; a_last_ok = 0; b_last_ok = 0;
        end else begin
            if (pend == 1) begin a_last = pend_data; a_last_ok = 1; end
            if (pend == 2) begin b_last = pend_data; b_last_ok = 1; end
            pend = 0;
            if (exp_win == 1) begin
                if (a_we) ref_mem[a_addr] = (ref_mem[a_addr] & ~expand(a_wmask))
                                            | (a_wdata & expand(a_wmask));
                else begin pend = 1; pend_data = ref_mem[a_addr]; end
            end else if (exp_win == 2) begin
                if (b_we) ref_mem[b_addr] = (ref_mem[b_addr] & ~expand(b_wmask))
                                            | (b_wdata & expand(b_wmask));
                else begin pend = 2; pend_data = ref_mem[b_addr]; end
            end
            if (b_req && exp_win != 2) waited = (waited + 1 > LIMIT) ? LIMIT : waited + 1;
            else                       waited = 0;
            case (lock_st)
                0: if (exp_win == 1 && a_lock) lock_st = 1;
                   else if (exp_win == 2 && b_lock) lock_st = 2;
                1: if (!a_req || !a_lock) lock_st = 0;
                default: if (!b_req || !b_lock) lock_st = 0;
            endcase
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic rand_fields(output logic req, output logic we, output logic lock,
                               output logic [AW-1:0] addr, output logic [NW-1:0] mask,
                               output logic [DW-1:0] data);
        req  = ($urandom_range(0, 99) < 60);
        we   = $urandom_range(0, 1) == 1;
        lock = ($urandom_range(0, 3) == 0);
        addr = AW'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0:       mask = '0;
            1:       mask = '1;
            default: mask = $urandom;
        endcase
        data = rand256();
    endtask

    int a0, b0;

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wmask = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wmask = '0; b_wdata = '0;

        // Reset held two cycles, then idle.
        cycle(); cycle();
        rst_n = 1'b1;
        cycle(); cycle();

        // A write then read of set 3.
        a_req = 1; a_we = 1; a_addr = 4'd3; a_wmask = '1; a_wdata = {32{8'hA5}};
        cycle();
        a_we = 0;
        cycle();
        a_req = 0;
        cycle();
        chk("a5_readback", a_rdata, {32{8'hA5}});

        // Both reading continuously: B forced through every fifth cycle.
        a_req = 1; a_we = 0; a_addr = 4'd3;
        b_req = 1; b_we = 0; b_addr = 4'd3; b_wmask = '0;
        a0 = a_gnt_seen; b0 = b_gnt_seen;
        for (int i = 0; i < 10; i++) cycle();
        chk("starve_a_grants", a_gnt_seen - a0, 8);
        chk("starve_b_grants", b_gnt_seen - b0, 2);
        a_req = 0; b_req = 0;
        cycle();

        // B burst lock on set 7 while A keeps requesting.
        b_req = 1; b_we = 0; b_addr = 4'd7; b_lock = 1;
        cycle();
        a_req = 1; a_we = 0; a_addr = 4'd0; a_lock = 0;
        a0 = a_gnt_seen; b0 = b_gnt_seen;
        cycle(); cycle();
        b_lock = 0;
        cycle();
        chk("lockb_a_blocked", a_gnt_seen - a0, 0);
        chk("lockb_b_grants", b_gnt_seen - b0, 3);
        b_req = 0;
        cycle();
        chk("lockb_a_after", a_gnt_seen - a0, 1);
        a_req = 0;
        cycle();

        // Partial write over an all-ones line.
        a_req = 1; a_we = 1; a_addr = 4'd5; a_wmask = '1; a_wdata = '1;
        cycle();
        a_wmask = 32'h0000_000F; a_wdata = {32{8'h11}};
        cycle();
        a_we = 0;
        cycle();
        a_req = 0;
        cycle();
        chk("partial_write", a_rdata, {{224{1'b1}}, 32'h1111_1111});

        // Locked B read, then reset: lock and pending state must be cleared.
        b_req = 1; b_we = 0; b_addr = 4'd5; b_lock = 1;
        cycle();
        rst_n = 0;
        cycle();
        rst_n = 1;
        a_req = 1; a_we = 0; a_addr = 4'd3; a_lock = 0;
        a0 = a_gnt_seen;
        cycle();
        chk("post_reset_a_wins", a_gnt_seen - a0, 1);
        a_req = 0; b_req = 0; b_lock = 0;
        cycle();

        // Randomized traffic; requesters hold fields until granted.
        for (int n = 0; n < 600; n++) begin
            if (!a_req || exp_win == 1) rand_fields(a_req, a_we, a_lock, a_addr, a_wmask, a_wdata);
            if (!b_req || exp_win == 2) rand_fields(b_req, b_we, b_lock, b_addr, b_wmask, b_wdata);
            rst_n = ($urandom_range(0, 149) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_array_arbiter.md
Name: data_array_arbiter

Overview:
- Shares one single-port data array between two requesters: port A (CPU hit path) and port B (fill/writeback path).
- The data array is a 256-bit, 16-set SRAM with 32 byte-enable bits. Its select and write-enable are both active-low, and it has a 1-cycle read latency.
- The block performs priority arbitration with starvation protection, holds burst locks, and steers read data back to the requester that issued the read.
- It sits between the cache control logic and the data array instance.

Parameters:
- DATA_WIDTH, 256, data bus width.
- ADDR_WIDTH, 4, set index width.
- NUM_WMASKS, 32, byte enables (DATA_WIDTH/8).
- STARVE_LIMIT, 4, number of consecutive cycles B may wait before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- a_req  in  1  port A request.
- a_we  in  1  port A write (1 = write, 0 = read).
- a_lock  in  1  port A requests to keep ownership after this access.
- a_addr  in  ADDR_WIDTH  port A set index.
- a_wmask  in  NUM_WMASKS  port A byte enables.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_gnt  out  1  port A access accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_WIDTH  port A read data.
- b_req, b_we, b_lock, b_addr, b_wmask, b_wdata, b_gnt, b_rvalid, b_rdata: same as the port A signals, for port B.
- csb0  out  1  SRAM chip select, active low.
- web0  out  1  SRAM write enable, active low.
- addr0  out  ADDR_WIDTH  SRAM address.
- wmask0  out  NUM_WMASKS  SRAM byte enables.
- din0  out  DATA_WIDTH  SRAM write data.
- dout0  in  DATA_WIDTH  SRAM read data, valid one cycle after the read issues.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State returns to IDLE; wait_cnt=0; rd_pend=0.
  - For the following cycle: a_rvalid=b_rvalid=0.
  - While rst_n=0: csb0=1, web0=1, a_gnt=b_gnt=0; addr0/wmask0/din0 are don't-care and are driven 0.
- State machine: IDLE, LOCK_A, LOCK_B (registered).
- Winner selection (combinational, same cycle as the request):
  - In IDLE:
    - A and B both requesting, wait_cnt < STARVE_LIMIT: A wins.
    - A and B both requesting, wait_cnt == STARVE_LIMIT: B wins.
    - Only one requesting: that port wins.
  - In LOCK_A: only A may win; B is ignored. Same rule for LOCK_B with B.
- Grant:
  - x_gnt=1 for the winner only; this is a zero-cycle handshake.
  - The requester holds its req and fields stable until it sees gnt.
  - Each grant is exactly one SRAM access.
- SRAM drive (combinational mux from the winner):
  - csb0=0, web0=~x_we, addr0/wmask0/din0 taken from the winner.
  - No winner: csb0=1, web0=1.
  - A write with wmask=0 is still granted and issued.
- Read return:
  - A granted read sets rd_pend and rd_owner at the edge.
  - Next cycle: x_rvalid=1 for rd_owner only; x_rdata=dout0.
  - The rdata of the non-owner port is held at its last value. rdata is don't-care when rvalid=0.
  - Back-to-back reads are allowed: a new read may be granted in the same cycle that the previous read's rvalid is shown.
- Lock transitions:
  - IDLE→LOCK_x: x granted with x_lock=1.
  - LOCK_x→IDLE: x granted with x_lock=0, or x_req=0 for a cycle.
  - Both cases are registered, so the other port may win on the next cycle.
- wait_cnt:
  - Increments when b_req=1 and B is not granted; saturates at STARVE_LIMIT.
  - Clears when B is granted or b_req=0.
  - Counts during LOCK_A too.
  - On exit from LOCK_A with wait_cnt==STARVE_LIMIT, B wins next.
- Simultaneous events:
  - In LOCK_A with a_req=0 and b_req=1, B is not granted that cycle: the unlock is registered first, and B is granted in the following cycle.
  - Starvation override never breaks an active lock.
- Reset mid-operation: a pending read is dropped (no rvalid); any lock is cleared.

Test Plan:
- Reset held 2 cycles, then released with no requests → csb0=1, web0=1, gnts=0, rvalids=0 on every cycle.
- A write addr=3, wmask=0xFFFFFFFF, wdata=0xA5…A5; next cycle A read addr=3 → a_gnt on both cycles; csb0=0, web0 0 then 1; a_rvalid one cycle after the read with a_rdata=0xA5…A5; b_rvalid=0.
- A and B both reading every cycle, STARVE_LIMIT=4 → A wins 4 cycles, B wins the 5th, then the pattern repeats; B's rvalid carries the data stored at b_addr.
- B read addr=7 with b_lock=1 for 3 grants, then b_lock=0, while a_req is held high → A is blocked during the 4 B grants; a_gnt first asserts on the cycle after B's unlocking grant.
- Partial write: wmask=0x0000000F, data=0x11…11 over a line holding 0xFF…FF; then read → rdata low 32 bits = 0x11111111, upper bits unchanged.
- Read granted, then rst_n=0 on the next edge → no rvalid on either port; state is IDLE and wait_cnt=0 after reset.
